// File: rtl/mem_loader_pkg.sv
// Shared definitions for the mem_loader block: default memory geometry, word
// packing and FSM state encoding. MEM_LOADER_CHECKSUM_EN enables the CHK states.
package mem_loader_pkg;

  localparam int LOADER_ADDR_W         = 12;
  localparam int LOADER_DATA_W         = 16;
  localparam int LOADER_BYTES_PER_WORD = 2;

  // Nine states exist when the checksum trailer is built in, so the encoding is 4 bits.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_WRITE  = 4'd5,
    ST_DONE   = 4'd6,
    ST_CHK_HI = 4'd7,
    ST_CHK_LO = 4'd8
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_CHK_HI, ST_CHK_LO: r = 1'b1;
      default:                                                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_loader_byte_pair_assembler.sv
// Pairs consecutive accepted stream bytes into a big-endian 16-bit word.
// word_valid pulses combinationally on the handshake of the second byte.
module mem_loader_byte_pair_assembler
  import mem_loader_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [7:0]                         byte_in,
  input  logic                               byte_fire,
  output logic [LOADER_BYTES_PER_WORD*8-1:0] word,
  output logic                               word_valid
);

  logic [7:0] hi_q;
  logic       lo_phase_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hi_q       <= '0;
      lo_phase_q <= 1'b0;
    end else if (byte_fire) begin
      if (!lo_phase_q) begin
        hi_q <= byte_in;
      end
      lo_phase_q <= ~lo_phase_q;
    end
  end

  assign word       = {hi_q, byte_in};
  assign word_valid = byte_fire & lo_phase_q;

endmodule

// File: rtl/mem_loader.sv
// Loads a length-prefixed big-endian word stream into block memory from address 0.
// Build with MEM_LOADER_CHECKSUM_EN to require a trailing 16-bit sum of the data words.
//
// Stream handshake: a byte moves when byte_valid and byte_ready are both high at a
// rising clk edge; byte_ready depends only on the current state, never on byte_valid.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written,
  output logic [3:0]        dbg_state
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     cnt_inc;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                err_q;
  logic                byte_fire;
  logic                start_ok;
  logic                len_bad;
  logic                last_word;
  logic [DATA_W-1:0]   asm_word;
  logic                asm_valid;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q;
`endif

  assign byte_ready = accepts_bytes(state_q);
  assign byte_fire  = byte_valid & byte_ready;
  assign start_ok   = start & ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign len_bad    = (asm_word == '0) || (32'(asm_word) > CAPACITY);
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_word  = (cnt_inc >= len_q);

  mem_loader_byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_in    (byte_in),
    .byte_fire  (byte_fire),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start)     state_d = ST_LEN_HI;
      ST_LEN_HI:        if (byte_fire) state_d = ST_LEN_LO;
      ST_LEN_LO:        if (asm_valid) state_d = len_bad ? ST_DONE : ST_DAT_HI;
      ST_DAT_HI:        if (byte_fire) state_d = ST_DAT_LO;
      ST_DAT_LO:        if (asm_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        if (!last_word) begin
          state_d = ST_DAT_HI;
        end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
          state_d = ST_CHK_HI;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CHK_HI:        if (byte_fire) state_d = ST_CHK_LO;
      ST_CHK_LO:        if (asm_valid) state_d = ST_DONE;
`endif
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        cnt_q  <= '0;
        addr_q <= '0;
        err_q  <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_q  <= '0;
`endif
      end
      if (state_q == ST_LEN_LO && asm_valid) begin
        if (len_bad) err_q <= 1'b1;
        else         len_q <= asm_word[ADDR_W:0];
      end
      if (state_q == ST_DAT_LO && asm_valid) begin
        din_q <= asm_word;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_q <= sum_q + asm_word;
`endif
      end
      // The address stops on the final write so a full-capacity load never wraps.
      if (state_q == ST_WRITE) begin
        cnt_q <= cnt_inc;
        if (!last_word) addr_q <= addr_q + 1'b1;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      if (state_q == ST_CHK_LO && asm_valid) begin
        err_q <= (asm_word != sum_q);
      end
`endif
    end
  end

  assign mem_we        = (state_q == ST_WRITE);
  assign mem_addr      = addr_q;
  assign mem_din       = din_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign error         = err_q;
  assign words_written = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: randomized streams against a reference model
// of the expected write list, plus a 2-cycle-latency block memory for read-back.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;
  logic        busy;
  logic        done;
  logic        error;
  logic [12:0] words_written;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  logic [15:0] stim_q[$];

  logic [15:0] bram [0:4095];
  logic [11:0] rd_addr = '0;
  logic [15:0] dout_p1, douta;

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .error(error), .words_written(words_written),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    dout_p1 <= bram[rd_addr];
    douta   <= dout_p1;
  end

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [27:0] e;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h din=%h", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} !== e) begin
          errors++;
          $display("FAIL write addr/din got=%h/%h exp=%h/%h", mem_addr, mem_din, e[27:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    logic took;
    waited = 0;
    took = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_in = b;
    byte_valid = 1'b1;
    while (!took && waited < 50) begin
      @(negedge clk);
      took = byte_ready;
      tick();
      waited++;
    end
    if (!took) begin
      checks++; errors++;
      $display("FAIL byte_timeout byte=%h ready=%b exp=1", b, byte_ready);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout done=%b exp=1", done);
    end
  endtask

  // Reference model: a valid length yields writes (i, word i) at addresses 0..len-1.
  task automatic run_load(input string name, input logic [15:0] len, input bit gaps, input bit corrupt);
    bit          ok_len;
    bit          exp_err;
    int          exp_wr;
    logic [15:0] sum;
    logic [15:0] chk;
    ok_len  = (len != 16'h0) && (len <= 16'h1000);
    exp_err = !ok_len;
    exp_wr  = ok_len ? int'(len) : 0;
    sum     = '0;
    do_start();
    send_byte(len[15:8], gaps);
    send_byte(len[7:0], gaps);
    if (ok_len) begin
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back({12'(i), stim_q[i]});
        sum += stim_q[i];
        send_byte(stim_q[i][15:8], gaps);
        send_byte(stim_q[i][7:0], gaps);
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      chk = corrupt ? sum + 16'd1 : sum;
      exp_err = corrupt;
      send_byte(chk[15:8], gaps);
      send_byte(chk[7:0], gaps);
`else
      chk = sum;
      if (corrupt && chk == 16'hFFFF) exp_err = exp_err;
`endif
    end
    byte_valid = 1'b0;
    wait_done();
    checks++;
    if (done !== 1'b1 || error !== exp_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s flags done/error/busy got=%b%b%b exp=1%b0", name, done, error, busy, exp_err);
    end
    checks++;
    if (words_written !== 13'(exp_wr)) begin
      errors++;
      $display("FAIL %s words_written got=%0d exp=%0d", name, words_written, exp_wr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes got=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(16'($urandom_range(0, 65535)));
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({byte_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== 12'h0 ||
        mem_din !== 16'h0 || words_written !== 13'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s outputs rdy/we/busy/done/err=%b%b%b%b%b addr=%h din=%h ww=%0d exp all 0",
               name, byte_ready, mem_we, busy, done, error, mem_addr, mem_din, words_written);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_accept ready=%b we=%b exp=0 0", byte_ready, mem_we);
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    stim_q = '{16'h1234, 16'hABCD, 16'h0007};
    run_load("basic", 16'h0003, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem_addr !== 12'h002) begin
      errors++;
      $display("FAIL done_hold done=%b addr=%h exp=1 002", done, mem_addr);
    end
    tick();
  endtask

  task automatic test_bad_len();
    stim_q.delete();
    run_load("len_zero", 16'h0000, 1'b0, 1'b0);
    run_load("len_1001", 16'h1001, 1'b0, 1'b0);
    run_load("len_rand", 16'($urandom_range(16'h1002, 16'hFFFF)), 1'b0, 1'b0);
  endtask

  task automatic test_full();
    int a;
    stim_q.delete();
    for (int i = 0; i < 4096; i++) stim_q.push_back(16'(i));
    run_load("full", 16'h1000, 1'b0, 1'b0);
    checks++;
    if (mem_addr !== 12'hFFF || mem_din !== 16'h0FFF) begin
      errors++;
      $display("FAIL full_last addr=%h din=%h exp=fff 0fff", mem_addr, mem_din);
    end
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 4095 : (k == 1) ? 0 : $urandom_range(1, 4094);
      rd_addr = 12'(a);
      tick(); tick();
      @(negedge clk);
      checks++;
      if (douta !== 16'(a)) begin
        errors++;
        $display("FAIL readback addr=%h got=%h exp=%h", rd_addr, douta, 16'(a));
      end
      tick();
    end
  endtask

  task automatic test_gaps();
    fill_random(2);
    run_load("gaps", 16'h0002, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      fill_random(n);
      run_load("random", 16'(n), bit'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_start_busy();
    fill_random(2);
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    byte_valid = 1'b0;
    do_start();
    exp_q.push_back({12'h000, stim_q[0]});
    exp_q.push_back({12'h001, stim_q[1]});
    for (int i = 0; i < 2; i++) begin
      send_byte(stim_q[i][15:8], 1'b0);
      send_byte(stim_q[i][7:0], 1'b0);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(8'(16'(stim_q[0] + stim_q[1]) >> 8), 1'b0);
    send_byte(8'(stim_q[0] + stim_q[1]), 1'b0);
`endif
    byte_valid = 1'b0;
    wait_done();
    checks++;
    if (error !== 1'b0 || words_written !== 13'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_busy err=%b ww=%0d left=%0d exp=0 2 0", error, words_written, exp_q.size());
      exp_q.delete();
    end
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("start_with_rst");
    tick();
  endtask

  task automatic test_reset_mid();
    fill_random(4);
    do_start();
    for (int i = 0; i < 4; i++) exp_q.push_back({12'(i), stim_q[i]});
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(stim_q[0][15:8], 1'b0);
    send_byte(stim_q[0][7:0], 1'b0);
    byte_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    checks++;
    if (exp_q.size() != 3) begin
      errors++;
      $display("FAIL reset_mid_writes got=%0d exp=1", 4 - exp_q.size());
    end
    exp_q.delete();
    tick();
    byte_valid = 1'b1;
    repeat (5) tick();
    byte_valid = 1'b0;
    fill_random(5);
    run_load("after_reset", 16'h0005, 1'b0, 1'b0);
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim_q = '{16'h0001, 16'h0002};
    run_load("chk_good", 16'h0002, 1'b0, 1'b0);
    run_load("chk_bad", 16'h0002, 1'b0, 1'b1);
    fill_random(7);
    run_load("chk_rand", 16'h0007, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_gaps();
    test_random();
    test_start_busy();
    test_reset_mid();
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
